// File: rtl/search_key_arbiter_pkg.sv
// Shared widths, FSM encodings and helpers for the search key arbiter.
package search_key_arbiter_pkg;
    localparam int KEY_W = 27;
    localparam int BV_W  = 36;

    typedef logic [KEY_W-1:0] key_t;
    typedef logic [BV_W-1:0]  bv_t;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction
endpackage

// File: rtl/search_key_arbiter_tag_fifo.sv
// Tag FIFO: remembers the issuing port of every in-flight key, oldest first.
module search_key_arbiter_tag_fifo
    import search_key_arbiter_pkg::*;
#(
    parameter int W     = 2,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] head_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push_s, do_pop_s;

    assign empty_o = (cnt_q == CW'(0));
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // Pop reads the old head before a same-cycle push can overwrite that slot.
    always_comb begin
        do_pop_s  = pop_i && !empty_o;
        do_push_s = push_i && (!full_o || do_pop_s);
        if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
        else           wr_ptr_d = wr_ptr_q;
        if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
        else           rd_ptr_d = rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag storage; slot contents only matter once written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/search_key_arbiter.sv
// Round-robin key arbiter in front of search_engine, with in-order BV return
// and a drain/hold handshake that freezes lookups for localbus table access.
module search_key_arbiter
    import search_key_arbiter_pkg::*;
#(
    parameter int NPORT = 4,
    parameter int PW    = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NPORT-1:0]       req_valid_i,
    input  logic [NPORT*KEY_W-1:0] req_key_i,
    output logic [NPORT-1:0]       req_ready_o,
    output logic                   key_valid_o,
    output logic [KEY_W-1:0]       key_o,
    input  logic                   bv_valid_i,
    input  logic [BV_W-1:0]        bv_i,
    output logic                   rsp_valid_o,
    output logic [PW-1:0]          rsp_port_o,
    output logic [BV_W-1:0]        rsp_bv_o,
    input  logic                   cfg_req_i,
    output logic                   cfg_ack_o,
    output logic                   err_orphan_o
);
    localparam int CW = clog2(DEPTH) + 1;

    logic [1:0]       state_q, state_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             key_valid_q, key_valid_d;
    key_t             key_q, key_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [PW-1:0]    rsp_port_q, rsp_port_d;
    bv_t              rsp_bv_q, rsp_bv_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             err_orphan_q, err_orphan_d;

    key_t             key_arr_s [NPORT];
    logic [PW-1:0]    cand_s, gnt_idx_s;
    logic             gnt_found_s, grant_en_s;
    logic [NPORT-1:0] req_ready_s;
    logic             accept_s, pop_s, orphan_s;
    logic [PW-1:0]    fifo_head_s;
    logic             fifo_empty_s, fifo_full_s;

    for (genvar g = 0; g < NPORT; g++) begin : g_key
        assign key_arr_s[g] = req_key_i[KEY_W*g +: KEY_W];
    end

    // A full tag FIFO is exactly cnt==DEPTH; its flag is registered, so a pop
    // in the full cycle reopens the grant only on the following cycle.
    assign grant_en_s = (state_q == ST_RUN) && !cfg_req_i && !fifo_full_s;

    // Circular first-valid search starting just after the last winner.
    always_comb begin
        cand_s      = '0;
        gnt_idx_s   = '0;
        gnt_found_s = 1'b0;
        for (int k = 1; k <= NPORT; k++) begin
            cand_s = PW'((int'(rr_ptr_q) + k) % NPORT);
            if (!gnt_found_s && req_valid_i[cand_s]) begin
                gnt_found_s = 1'b1;
                gnt_idx_s   = cand_s;
            end else begin
                gnt_found_s = gnt_found_s;
            end
        end
        req_ready_s = '0;
        if (grant_en_s && gnt_found_s) req_ready_s[gnt_idx_s] = 1'b1;
        else                           req_ready_s = '0;
    end

    // Issue, return, occupancy, orphan detection and the cfg handshake.
    always_comb begin
        accept_s    = |(req_valid_i & req_ready_s);
        pop_s       = bv_valid_i && !fifo_empty_s;
        orphan_s    = bv_valid_i && fifo_empty_s;
        key_valid_d = accept_s;
        rsp_valid_d = pop_s;
        if (accept_s) begin
            key_d    = key_arr_s[gnt_idx_s];
            rr_ptr_d = gnt_idx_s;
        end else begin
            key_d    = key_q;
            rr_ptr_d = rr_ptr_q;
        end
        if (pop_s) begin
            rsp_port_d = fifo_head_s;
            rsp_bv_d   = bv_i;
        end else begin
            rsp_port_d = rsp_port_q;
            rsp_bv_d   = rsp_bv_q;
        end
        case ({accept_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        if (orphan_s) err_orphan_d = 1'b1;
        else          err_orphan_d = err_orphan_q;
        case (state_q)
            ST_RUN: begin
                if (cfg_req_i) state_d = ST_DRAIN;
                else           state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (!cfg_req_i)                                    state_d = ST_RUN;
                else if ((cnt_q == CW'(0)) && !key_valid_q)        state_d = ST_HOLD;
                else                                               state_d = ST_DRAIN;
            end
            ST_HOLD: begin
                if (!cfg_req_i) state_d = ST_RUN;
                else            state_d = ST_HOLD;
            end
            default: state_d = ST_RUN;
        endcase
        cfg_ack_d = (state_d == ST_HOLD);
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_RUN;
            rr_ptr_q     <= PW'(NPORT - 1);
            cnt_q        <= '0;
            key_valid_q  <= 1'b0;
            key_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_port_q   <= '0;
            rsp_bv_q     <= '0;
            cfg_ack_q    <= 1'b0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            key_valid_q  <= key_valid_d;
            key_q        <= key_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_port_q   <= rsp_port_d;
            rsp_bv_q     <= rsp_bv_d;
            cfg_ack_q    <= cfg_ack_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    search_key_arbiter_tag_fifo #(
        .W     (PW),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (accept_s),
        .push_data_i (gnt_idx_s),
        .pop_i       (pop_s),
        .head_o      (fifo_head_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

    assign req_ready_o  = req_ready_s;
    assign key_valid_o  = key_valid_q;
    assign key_o        = key_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_port_o   = rsp_port_q;
    assign rsp_bv_o     = rsp_bv_q;
    assign cfg_ack_o    = cfg_ack_q;
    assign err_orphan_o = err_orphan_q;
endmodule

// File: tb/tb_search_key_arbiter.sv
// Bench for search_key_arbiter: directed vector table, corner-case sequences
// and a randomized run against a queue-based reference model.
module tb_search_key_arbiter;
    import search_key_arbiter_pkg::*;

    localparam int NP = 4;
    localparam int PWL = 2;
    localparam int DP = 8;
    localparam int M_RUN = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HOLD = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NP-1:0]       req_valid;
    logic [NP*KEY_W-1:0] req_key;
    logic [NP-1:0]       req_ready;
    logic                key_valid;
    logic [KEY_W-1:0]    key;
    logic                bv_valid;
    logic [BV_W-1:0]     bv;
    logic                rsp_valid;
    logic [PWL-1:0]      rsp_port;
    logic [BV_W-1:0]     rsp_bv;
    logic                cfg_req;
    logic                cfg_ack;
    logic                err_orphan;

    search_key_arbiter #(.NPORT(NP), .PW(PWL), .DEPTH(DP)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_valid_i  (req_valid),
        .req_key_i    (req_key),
        .req_ready_o  (req_ready),
        .key_valid_o  (key_valid),
        .key_o        (key),
        .bv_valid_i   (bv_valid),
        .bv_i         (bv),
        .rsp_valid_o  (rsp_valid),
        .rsp_port_o   (rsp_port),
        .rsp_bv_o     (rsp_bv),
        .cfg_req_i    (cfg_req),
        .cfg_ack_o    (cfg_ack),
        .err_orphan_o (err_orphan)
    );

    int total = 0;
    int bad = 0;

    // Reference model: in-flight issuers as a queue, plus expected outputs.
    int               mq[$];
    int               m_last;
    int               m_mode;
    bit               m_err, m_kv, m_rv, m_ack;
    logic [KEY_W-1:0] m_key;
    int               m_rport;
    logic [BV_W-1:0]  m_rbv;

    logic [KEY_W-1:0] keys [NP];
    logic [NP-1:0]    last_rdy;

    typedef struct {
        bit            rst;
        logic [NP-1:0] rv;
        bit            bvv;
        bit            cfg;
        logic [NP-1:0] e_rdy;
        bit            e_kv;
        int            e_kport;
        bit            e_rv;
        int            e_rport;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP-1:0] m_ready();
        logic [NP-1:0] r;
        r = '0;
        if (m_mode == M_RUN && !cfg_req && mq.size() < DP) begin
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_last + k) % NP;
                if (req_valid[p]) begin
                    r[p] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_last = NP - 1;
        m_mode = M_RUN;
        m_err = 0; m_kv = 0; m_rv = 0; m_ack = 0;
        m_key = '0; m_rport = 0; m_rbv = '0;
    endtask

    task automatic m_edge(input logic [NP-1:0] rdy);
        bit empty0, kv0, acc;
        int n0, acc_p;
        empty0 = (mq.size() == 0);
        n0 = mq.size();
        kv0 = m_kv;
        acc = 0; acc_p = 0;
        for (int p = 0; p < NP; p++) begin
            if (rdy[p] && req_valid[p]) begin
                acc = 1; acc_p = p;
            end
        end
        m_kv = acc;
        if (acc) m_key = keys[acc_p];
        m_rv = 0;
        if (bv_valid) begin
            if (empty0) m_err = 1;
            else begin
                m_rv = 1;
                m_rport = mq.pop_front();
                m_rbv = bv;
            end
        end
        if (acc) begin
            mq.push_back(acc_p);
            m_last = acc_p;
        end
        case (m_mode)
            M_RUN:   if (cfg_req) m_mode = M_DRAIN;
            M_DRAIN: if (!cfg_req) m_mode = M_RUN;
                     else if (n0 == 0 && !kv0) m_mode = M_HOLD;
            default: if (!cfg_req) m_mode = M_RUN;
        endcase
        m_ack = (m_mode == M_HOLD);
    endtask

    // One clock cycle: drive, check grant before the edge, check outputs after.
    task automatic cyc(input logic [NP-1:0] rv, input bit bvv, input logic [BV_W-1:0] bvd, input bit cfg);
        logic [NP-1:0] er;
        req_valid = rv;
        bv_valid = bvv;
        bv = bvd;
        cfg_req = cfg;
        for (int p = 0; p < NP; p++) req_key[p*KEY_W +: KEY_W] = keys[p];
        #1;
        er = m_ready();
        last_rdy = req_ready;
        chk("req_ready", req_ready, er);
        @(posedge clk);
        m_edge(er);
        #1;
        chk("key_valid", key_valid, m_kv);
        if (m_kv) chk("key", key, m_key);
        chk("rsp_valid", rsp_valid, m_rv);
        chk("rsp_port", rsp_port, m_rport);
        chk("rsp_bv", rsp_bv, m_rbv);
        chk("cfg_ack", cfg_ack, m_ack);
        chk("err_orphan", err_orphan, m_err);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req_valid = '0; bv_valid = 1'b0; bv = '0; cfg_req = 1'b0;
        @(posedge clk);
        #1;
        m_reset();
        chk("rst_key_valid", key_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_port", rsp_port, 0);
        chk("rst_rsp_bv", rsp_bv, 0);
        chk("rst_cfg_ack", cfg_ack, 0);
        chk("rst_err", err_orphan, 0);
        req_valid = 4'b1111;
        #1;
        chk("rst_first_winner", req_ready, 4'b0001);
        req_valid = '0;
        reset = 1'b1;
    endtask

    function automatic vec_t mk(bit rst, logic [NP-1:0] rv, bit bvv, bit cfg, logic [NP-1:0] e_rdy,
                                bit e_kv, int e_kport, bit e_rv, int e_rport);
        vec_t v;
        v.rst = rst; v.rv = rv; v.bvv = bvv; v.cfg = cfg; v.e_rdy = e_rdy;
        v.e_kv = e_kv; v.e_kport = e_kport; v.e_rv = e_rv; v.e_rport = e_rport;
        return v;
    endfunction

    int nacc, nrsp, rsp3, ackc, cfg_left;
    bit bvv_r;
    logic [NP-1:0] pend;
    int acc_cnt [NP];

    initial begin
        for (int p = 0; p < NP; p++) keys[p] = 27'h1234560 + 27'(p);
        req_key = '0;
        m_reset();

        // Ports 0 and 2, then in-order return two cycles later.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0101, 0, 0, 4'b0001, 1, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0100, 0, 0, 4'b0100, 1, 2, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 2));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));
        // All ports busy: strict rotation, then the full condition.
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0, 0));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 4'b1111, 0, 0, 4'b0001 << (i % 4), 1, i % 4, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 0, 4'b0000, 0, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, 1, 0, 4'b0000, 0, 0, 1, 0));
        vecs.push_back(mk(0, 4'b1111, 0, 0, 4'b0001, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            else begin
                cyc(vecs[i].rv, vecs[i].bvv, 36'h0A0000000 + 36'(i), vecs[i].cfg);
                chk("tbl_ready", last_rdy, vecs[i].e_rdy);
                chk("tbl_key_valid", key_valid, vecs[i].e_kv);
                if (vecs[i].e_kv) chk("tbl_key", key, keys[vecs[i].e_kport]);
                chk("tbl_rsp_valid", rsp_valid, vecs[i].e_rv);
                if (vecs[i].e_rv) chk("tbl_rsp_port", rsp_port, vecs[i].e_rport);
            end
        end

        // Stalled engine with port 1 streaming.
        do_reset();
        nacc = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(4'b0010, 0, '0, 0);
            if (last_rdy[1]) nacc++;
        end
        chk("stall_accepts", nacc, 8);
        cyc(4'b0010, 1, 36'h0B0000001, 0);
        chk("ready_in_pop_cycle", last_rdy, 4'b0000);
        cyc(4'b0010, 0, '0, 0);
        chk("ready_after_pop", last_rdy, 4'b0010);

        // Accept and return on the same edge: occupancy stays put.
        cyc(4'b0000, 1, 36'h0B0000002, 0);
        nacc = 0; nrsp = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(4'b1111, 1, 36'({$urandom, $urandom}), 0);
            if (last_rdy != 4'b0000) nacc++;
            if (rsp_valid) nrsp++;
        end
        chk("steady_accepts", nacc, 20);
        chk("steady_returns", nrsp, 20);

        // Quiesce with three keys in flight.
        do_reset();
        cyc(4'b0001, 0, '0, 0);
        cyc(4'b0010, 0, '0, 0);
        cyc(4'b0100, 0, '0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1000, 0, '0, 1);
            chk("drain_no_key", key_valid, 0);
        end
        nrsp = 0; rsp3 = -1; ackc = -1;
        for (int c = 0; c < 6; c++) begin
            cyc(4'b1000, c < 3, 36'h0C0000000 + 36'(c), 1);
            if (rsp_valid) begin
                nrsp++;
                if (nrsp == 3) rsp3 = c;
            end
            if (cfg_ack && ackc < 0) ackc = c;
        end
        chk("ack_after_third_rsp", ackc, rsp3 + 1);
        chk("ack_held", cfg_ack, 1);
        cyc(4'b1000, 0, '0, 0);
        chk("hold_exit_ready", last_rdy, 4'b0000);
        chk("ack_dropped", cfg_ack, 0);
        cyc(4'b1000, 0, '0, 0);
        chk("resume_ready", last_rdy, 4'b1000);
        chk("resume_key", key, keys[3]);
        // cfg_req withdrawn mid-drain: no ack pulse.
        cyc(4'b0000, 0, '0, 1);
        cyc(4'b0000, 0, '0, 0);
        chk("abort_no_ack", cfg_ack, 0);
        cyc(4'b0000, 1, 36'h0C00000FF, 0);
        chk("abort_rsp_port", rsp_port, 3);

        // Orphan returns, including a stale one after a mid-flight reset.
        do_reset();
        cyc(4'b0000, 1, 36'h123456789, 0);
        chk("orphan_err", err_orphan, 1);
        chk("orphan_no_rsp", rsp_valid, 0);
        cyc(4'b0000, 0, '0, 0);
        chk("orphan_sticky", err_orphan, 1);
        do_reset();
        cyc(4'b0001, 0, '0, 0);
        cyc(4'b0010, 0, '0, 0);
        do_reset();
        cyc(4'b0000, 1, 36'h0D0000000, 0);
        chk("stale_err", err_orphan, 1);

        // Randomized traffic against the model.
        do_reset();
        pend = '0; cfg_left = 0;
        for (int p = 0; p < NP; p++) acc_cnt[p] = 0;
        for (int i = 0; i < 3000; i++) begin
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    keys[p] = 27'($urandom);
                end
            end
            bvv_r = (mq.size() > 0) && ($urandom_range(0, 1) == 1);
            if (cfg_left > 0) cfg_left--;
            else if ($urandom_range(0, 40) == 0) cfg_left = $urandom_range(1, 30);
            cyc(pend, bvv_r, 36'({$urandom, $urandom}), cfg_left > 0);
            for (int p = 0; p < NP; p++) begin
                if (last_rdy[p]) begin
                    pend[p] = 1'b0;
                    acc_cnt[p]++;
                end
            end
        end
        for (int p = 0; p < NP; p++) chk("port_served", acc_cnt[p] > 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
